// File: rtl/mips_mem_arbiter.sv
// Arbitrates the single external memory port between the I-cache and D-cache.
// Data side wins by default; a saturating starve counter forces an instruction grant.
module mips_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic [31:0] i_rdata,
  output logic        i_dvalid,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_dvalid,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_dvalid,
  output logic        bus_error
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          bus_error_q, bus_error_d;

  logic busy;
  logic tmo_hit;
  logic finish;

  assign busy    = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
  // A real mem_dvalid in the last allowed cycle still counts as a good completion.
  assign tmo_hit = busy && !mem_dvalid && (tmo_q == TMO_LAST);
  assign finish  = busy && (mem_dvalid || tmo_hit);

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_error_d = bus_error_q | tmo_hit;
    i_dvalid    = 1'b0;
    d_dvalid    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_read && (starve_q == STARVE_MAX)) begin
          state_d  = I_RD;
          addr_d   = i_addr;
          starve_d = '0;
          tmo_d    = '0;
        end else if (d_write || d_read) begin
          state_d = d_write ? D_WR : D_RD;
          addr_d  = d_addr;
          tmo_d   = '0;
          if (d_write) begin
            wdata_d = d_writedata;
            be_d    = d_byteenable;
          end
          if (!i_read) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (i_read) begin
          state_d  = I_RD;
          addr_d   = i_addr;
          starve_d = '0;
          tmo_d    = '0;
        end
      end
      I_RD: begin
        if (finish) begin
          i_dvalid  = 1'b1;
          i_rdata_d = mem_dvalid ? mem_rdata : '0;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      D_RD: begin
        if (finish) begin
          d_dvalid  = 1'b1;
          d_rdata_d = mem_dvalid ? mem_rdata : '0;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      D_WR: begin
        if (finish) begin
          d_dvalid = 1'b1;
          state_d  = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign mem_read       = (state_q == I_RD) || (state_q == D_RD);
  assign mem_write      = (state_q == D_WR);
  assign mem_addr       = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign i_rdata        = i_rdata_d;
  assign d_rdata        = d_rdata_d;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: directed cache requests, a latency-programmable
// memory model, and a monitor that checks memory transactions and completions in order.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, d_addr, d_writedata, mem_rdata;
  logic        i_read, d_read, d_write, mem_dvalid;
  logic [3:0]  d_byteenable;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_writedata;
  logic        i_dvalid, d_dvalid, mem_read, mem_write, bus_error;
  logic [3:0]  mem_byteenable;

  mips_mem_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_addr         (i_addr),
    .i_read         (i_read),
    .i_rdata        (i_rdata),
    .i_dvalid       (i_dvalid),
    .d_addr         (d_addr),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_writedata    (d_writedata),
    .d_byteenable   (d_byteenable),
    .d_rdata        (d_rdata),
    .d_dvalid       (d_dvalid),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_rdata      (mem_rdata),
    .mem_dvalid     (mem_dvalid),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          len;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } resp_t;

  mem_exp_t    mq[$];
  resp_t       iq[$];
  resp_t       dq[$];
  logic [31:0] mem_data [logic [31:0]];

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  bit late_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: completes on the lat-th strobe cycle; lat==0 never completes.
  initial begin
    int cnt = 0;
    mem_dvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        cnt++;
        if (lat != 0 && cnt == lat) begin
          mem_dvalid = 1'b1;
          mem_rdata  = mem_data.exists(mem_addr) ? mem_data[mem_addr] : 32'h0;
        end else begin
          mem_dvalid = 1'b0;
          mem_rdata  = 32'hBAD0_BAD0;
        end
      end else begin
        cnt        = 0;
        mem_dvalid = late_pulse;
        mem_rdata  = 32'h5555_AAAA;
        late_pulse = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT starts a memory transaction or completes.
  initial begin
    mem_exp_t    cur;
    resp_t       r;
    bit          prev = 1'b0, active = 1'b0, held = 1'b1;
    int          len = 0;
    logic [31:0] last_i = '0, last_d = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        last_i = '0;
        last_d = '0;
      end
      if (mem_read && mem_write) check("strobe_excl", 32'd1, 32'd0);
      if ((mem_read || mem_write) && !prev) begin
        if (mq.size() == 0) begin
          check("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
          active = 1'b0;
        end else begin
          cur = mq.pop_front();
          check("mem_addr", mem_addr, cur.addr);
          check("mem_write", {31'b0, mem_write}, {31'b0, cur.wr});
          check("mem_read", {31'b0, mem_read}, {31'b0, ~cur.wr});
          if (cur.wr) begin
            check("mem_wdata", mem_writedata, cur.wd);
            check("mem_be", {28'b0, mem_byteenable}, {28'b0, cur.be});
          end
          active = 1'b1;
          held   = 1'b1;
          len    = 1;
        end
      end else if ((mem_read || mem_write) && active) begin
        len++;
        if (mem_addr !== cur.addr || mem_write !== cur.wr ||
            (cur.wr && (mem_writedata !== cur.wd || mem_byteenable !== cur.be)))
          held = 1'b0;
      end else if (!(mem_read || mem_write) && prev && active) begin
        active = 1'b0;
        if (cur.len != 0) check("strobe_len", 32'(len), 32'(cur.len));
        check("mem_held", {31'b0, held}, 32'd1);
      end
      prev = mem_read || mem_write;

      if (i_dvalid) begin
        if (iq.size() == 0) check("i_dvalid_unexpected", 32'd1, 32'd0);
        else begin
          r = iq.pop_front();
          if (r.chk) check("i_rdata", i_rdata, r.data);
        end
        check("d_rdata_hold", d_rdata, last_d);
        last_i = i_rdata;
      end
      if (d_dvalid) begin
        if (dq.size() == 0) check("d_dvalid_unexpected", 32'd1, 32'd0);
        else begin
          r = dq.pop_front();
          if (r.chk) check("d_rdata", d_rdata, r.data);
        end
        check("i_rdata_hold", i_rdata, last_i);
        last_d = d_rdata;
      end
    end
  end

  task automatic wait_done(input string name, input bit side_d);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (side_d ? d_dvalid : i_dvalid) break;
    end
    if (k == 200) check(name, 32'd0, 32'd1);
    #1;
  endtask

  task automatic i_req(input logic [31:0] a);
    i_addr = a;
    i_read = 1'b1;
    wait_done("i_timeout", 1'b0);
    i_read = 1'b0;
  endtask

  task automatic d_req(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] be);
    d_addr       = a;
    d_writedata  = wd;
    d_byteenable = be;
    d_read       = ~wr;
    d_write      = wr;
    wait_done("d_timeout", 1'b1);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic push_mem(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] be, input int len);
    mem_exp_t e;
    e.addr = a; e.wr = wr; e.wd = wd; e.be = be; e.len = len;
    mq.push_back(e);
  endtask

  task automatic push_resp(input bit side_d, input logic [31:0] data, input bit chk);
    resp_t r;
    r.data = data;
    r.chk  = chk;
    if (side_d) dq.push_back(r);
    else        iq.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_bus_error", {31'b0, bus_error}, 32'd0);
    check("rst_dvalid", {30'b0, i_dvalid, d_dvalid}, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    #1 rst = 1'b0;

    // single instruction fill, 3-cycle memory latency
    lat = 3;
    mem_data[32'h10] = 32'hDEAD_BEEF;
    push_mem(32'h10, 1'b0, '0, '0, 3);
    push_resp(1'b0, 32'hDEAD_BEEF, 1'b1);
    i_req(32'h10);
    @(negedge clk);
    #1;
    check("done_no_strobe", {30'b0, mem_read, mem_write}, 32'd0);
    #1;

    // simultaneous requests: data first, then instruction
    lat = 2;
    mem_data[32'h20] = 32'h1111_2222;
    mem_data[32'h40] = 32'h3333_4444;
    push_mem(32'h40, 1'b0, '0, '0, 2);
    push_mem(32'h20, 1'b0, '0, '0, 2);
    push_resp(1'b1, 32'h3333_4444, 1'b1);
    push_resp(1'b0, 32'h1111_2222, 1'b1);
    fork
      i_req(32'h20);
      d_req(32'h40, 1'b0, '0, '0);
    join

    // data write with byte lanes
    lat = 4;
    push_mem(32'h08, 1'b1, 32'h0000_0049, 4'b0101, 4);
    push_resp(1'b1, '0, 1'b0);
    d_req(32'h08, 1'b1, 32'h0000_0049, 4'b0101);

    // starvation guard: D,D,D,D,I,D
    lat = 2;
    mem_data[32'h200] = 32'hCAFE_0001;
    for (int k = 0; k < 4; k++) begin
      mem_data[32'h100 + 32'(4 * k)] = 32'hD000_0000 + 32'(k);
      push_mem(32'h100 + 32'(4 * k), 1'b0, '0, '0, 2);
      push_resp(1'b1, 32'hD000_0000 + 32'(k), 1'b1);
    end
    push_mem(32'h200, 1'b0, '0, '0, 2);
    push_resp(1'b0, 32'hCAFE_0001, 1'b1);
    mem_data[32'h110] = 32'hD000_0004;
    push_mem(32'h110, 1'b0, '0, '0, 2);
    push_resp(1'b1, 32'hD000_0004, 1'b1);
    fork
      i_req(32'h200);
      begin
        for (int k = 0; k < 5; k++) d_req(32'h100 + 32'(4 * k), 1'b0, '0, '0);
      end
    join

    // timeout: memory never answers; abort after 8 busy cycles with zero data
    lat = 0;
    push_mem(32'h300, 1'b0, '0, '0, 8);
    push_resp(1'b1, 32'h0, 1'b1);
    d_req(32'h300, 1'b0, '0, '0);
    @(negedge clk);
    #1;
    check("bus_error_set", {31'b0, bus_error}, 32'd1);
    #1;
    lat = 2;
    mem_data[32'h304] = 32'h5A5A_5A5A;
    push_mem(32'h304, 1'b0, '0, '0, 2);
    push_resp(1'b0, 32'h5A5A_5A5A, 1'b1);
    i_req(32'h304);
    @(negedge clk);
    #1;
    check("bus_error_sticky", {31'b0, bus_error}, 32'd1);
    #1;

    // reset in the middle of a data read, then a stray mem_dvalid in IDLE
    lat = 0;
    push_mem(32'h400, 1'b0, '0, '0, 0);
    d_addr = 32'h400;
    d_read = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst    = 1'b1;
    d_read = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("midrst_dvalid", {30'b0, i_dvalid, d_dvalid}, 32'd0);
    check("midrst_bus_error", {31'b0, bus_error}, 32'd0);
    check("midrst_i_rdata", i_rdata, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    #1 rst = 1'b0;
    late_pulse = 1'b1;
    @(negedge clk);
    #1;
    check("late_dvalid_in", {31'b0, mem_dvalid}, 32'd1);
    check("late_ignored", {30'b0, i_dvalid, d_dvalid}, 32'd0);
    @(negedge clk);
    #1;
    check("late_no_grant", {30'b0, mem_read, mem_write}, 32'd0);
    repeat (2) @(negedge clk);

    check("mq_drained", 32'(mq.size()), 32'd0);
    check("iq_drained", 32'(iq.size()), 32'd0);
    check("dq_drained", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares the single external memory port between the instruction cache and the data cache. Each cache raises a miss (fill) request, or a data write-through request, and holds it until it sees a completion pulse. The arbiter grants one requester at a time and routes the memory read data back to the winner. Data side has priority, and a starvation guard protects the instruction side.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits; the next grant then goes to instruction.
TIMEOUT_CYCLES, 64, busy cycles without mem_dvalid before the transaction is aborted.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_addr  in  32  instruction fill address
i_read  in  1  instruction fill request; held until i_dvalid
i_rdata  out  32  fill data to instruction cache
i_dvalid  out  1  one-cycle completion pulse to instruction cache
d_addr  in  32  data address
d_read  in  1  data fill request; held until d_dvalid
d_write  in  1  data write request; held until d_dvalid
d_writedata  in  32  write data
d_byteenable  in  4  write byte lanes
d_rdata  out  32  fill data to data cache
d_dvalid  out  1  one-cycle completion pulse to data cache
mem_addr  out  32  memory address, registered at grant
mem_read  out  1  memory read strobe, held for whole read transaction
mem_write  out  1  memory write strobe, held for whole write transaction
mem_writedata  out  32  registered write data
mem_byteenable  out  4  registered byte lanes
mem_rdata  in  32  memory read data, valid with mem_dvalid
mem_dvalid  in  1  memory completion (read data valid or write done)
bus_error  out  1  sticky timeout flag

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- Reset (sync, any state): state goes to IDLE next edge. mem_read, mem_write, i_dvalid, d_dvalid and bus_error go to 0. mem_addr, mem_writedata, mem_byteenable, i_rdata and d_rdata go to 0. Starve and timeout counters go to 0. An in-flight memory transaction is abandoned; no completion pulse is issued.
- IDLE grant, evaluated from requests sampled in the current cycle:
  - If i_read is pending and starve count = STARVE_LIMIT: go to I_RD.
  - Else if d_write: go to D_WR.
  - Else if d_read: go to D_RD.
  - Else if i_read: go to I_RD.
  - Else stay in IDLE.
- d_read and d_write both high is treated as a write; the read is ignored.
- On grant, the winner's address is latched into mem_addr (plus writedata/byteenable for writes). mem_read or mem_write is asserted from the next cycle, so a request in cycle N gives a strobe in cycle N+1.
- Busy states hold the strobe and all mem_* outputs constant until mem_dvalid.
- Completion, in the cycle mem_dvalid=1:
  - The winner's *_dvalid=1 combinationally in that cycle.
  - For reads, the winner's *_rdata = mem_rdata in that cycle, then held until the next completion to that side.
  - The strobe drops at the next edge; state goes to DONE.
- DONE lasts exactly one cycle with no grant, no strobe and dvalid low, so the requester can drop its request. Then IDLE.
- mem_dvalid while in IDLE or DONE is ignored.
- Starve counter:
  - Increments on each data grant made while i_read is high, saturating at STARVE_LIMIT.
  - Clears on every instruction grant.
  - Clears on any grant made while i_read is low.
- Timeout:
  - The counter runs in busy states and clears on entry to each busy state.
  - When it reaches TIMEOUT_CYCLES-1 with no mem_dvalid, the transaction is aborted: the winner gets a dvalid pulse with rdata=32'h0, bus_error is set, state goes to DONE.
  - bus_error stays set until rst.
- The non-granted requester sees dvalid=0 throughout and its rdata holds its previous value.
- Only one of mem_read/mem_write is ever high. Neither is high in IDLE or DONE.

Test Plan:
- Single instruction fill: i_read=1, i_addr=0x10, memory responds after 3 cycles with 0xDEADBEEF -> mem_read high 3 cycles with mem_addr=0x10, i_dvalid single pulse with i_rdata=0xDEADBEEF, d_dvalid stays 0, one DONE cycle before next grant.
- Simultaneous requests: i_read and d_read rise together (i_addr=0x20, d_addr=0x40) -> data served first (mem_addr=0x40), instruction served after DONE (mem_addr=0x20), each side receives only its own data.
- Data write: d_write=1, d_addr=0x08, d_writedata=0x00000049, d_byteenable=4'b0101 -> mem_write held with those registered values until mem_dvalid, mem_read never high, d_dvalid pulses once.
- Starvation guard, STARVE_LIMIT=4: d_read held continuously with i_read held -> grant order D,D,D,D,I,D..., starve count returns to 0 after the instruction grant.
- Timeout, TIMEOUT_CYCLES=8: memory never asserts mem_dvalid on a d_read -> abort after 8 busy cycles, d_dvalid pulses with d_rdata=0, bus_error=1 and stays 1 through later good transactions until rst.
- Reset mid-read: rst=1 during a D_RD -> next cycle all mem strobes 0, no dvalid pulse, bus_error=0. A late mem_dvalid arriving in IDLE is ignored.
